// File: rtl/ccd_line_capture.sv
// CCD line capture: watches the sequencer phase clocks, samples reset/signal levels and
// emits CDS pixels on a valid/ready stream. Define CCD_RX_SYNC_EN to add 2-flop phase syncs.
module ccd_line_capture #(
  parameter int unsigned ADC_W  = 12,
  parameter int unsigned NPIX   = 2051,
  parameter int unsigned SETTLE = 8,
  parameter int unsigned CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phi_p,
  input  logic             phi_l1,
  input  logic             phi_l2,
  input  logic             phi_r,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] pix_data,
  output logic [CNT_W-1:0] pix_idx,
  output logic             pix_sol,
  output logic             pix_eol,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             line_done,
  output logic             ovf_err,
  output logic             seq_err
);

  localparam int unsigned SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StRstWait,
    StSigWait,
    StLineEnd
  } state_e;

  state_e state, state_d;

  // phi_l2 carries no timing information this receiver needs
  logic unused_phi_l2;
  assign unused_phi_l2 = phi_l2;

  // Phase inputs packed as {p, l1, r}
  logic [2:0] phi_raw, phi_s, phi_q1, phi_q2;
  assign phi_raw = {phi_p, phi_l1, phi_r};

`ifdef CCD_RX_SYNC_EN
  logic [2:0] phi_sync1, phi_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi_sync1 <= '0;
      phi_sync2 <= '0;
    end else begin
      phi_sync1 <= phi_raw;
      phi_sync2 <= phi_sync1;
    end
  end

  assign phi_s = phi_sync2;
`else
  assign phi_s = phi_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi_q1 <= '0;
      phi_q2 <= '0;
    end else begin
      phi_q1 <= phi_s;
      phi_q2 <= phi_q1;
    end
  end

  logic p_rise, p_fall, l1_rise, r_fall, p_l1_overlap;
  assign p_rise       =  phi_q1[2] & ~phi_q2[2];
  assign p_fall       = ~phi_q1[2] &  phi_q2[2];
  assign l1_rise      =  phi_q1[1] & ~phi_q2[1];
  assign r_fall       = ~phi_q1[0] &  phi_q2[0];
  assign p_l1_overlap =  phi_q1[2] &  phi_q1[1];

  logic [SW-1:0]    settle_cnt;
  logic [CNT_W-1:0] idx;
  logic             rst_valid;
  logic [ADC_W-1:0] rst_smp;

  logic cnt_done, idx_last;
  // Counter is loaded with SETTLE on the edge cycle; reaching 1 marks the SETTLE-th cycle
  assign cnt_done = (settle_cnt == SW'(1));
  assign idx_last = (idx == CNT_W'(NPIX - 1));

  logic [ADC_W:0]   cds_diff;
  logic [ADC_W-1:0] cds_pix;
  assign cds_diff = {1'b0, rst_smp} - {1'b0, adc_data};
  assign cds_pix  = cds_diff[ADC_W] ? '0 : cds_diff[ADC_W-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      StIdle: begin
        if (p_fall) state_d = StArmed;
      end
      StArmed: begin
        if (p_rise) begin
          state_d = StIdle;
        end else if (r_fall) begin
          state_d = StRstWait;
        end else if (l1_rise && rst_valid) begin
          state_d = StSigWait;
        end
      end
      StRstWait: begin
        if (p_rise) begin
          state_d = StIdle;
        end else if (cnt_done) begin
          state_d = StArmed;
        end
      end
      StSigWait: begin
        if (p_rise) begin
          state_d = StIdle;
        end else if (cnt_done) begin
          state_d = idx_last ? StLineEnd : StArmed;
        end
      end
      StLineEnd: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  logic line_start, cnt_load, smp_rst, emit, seq_set;

  // Output / control decode
  always_comb begin
    line_start = 1'b0;
    cnt_load   = 1'b0;
    smp_rst    = 1'b0;
    emit       = 1'b0;
    seq_set    = p_l1_overlap;
    line_done  = 1'b0;
    unique case (state)
      StIdle: begin
        line_start = p_fall;
      end
      StArmed: begin
        cnt_load = !p_rise && (r_fall || (l1_rise && rst_valid));
        seq_set  = seq_set | p_rise;
      end
      StRstWait: begin
        smp_rst = !p_rise && cnt_done;
        seq_set = seq_set | p_rise | r_fall | l1_rise;
      end
      StSigWait: begin
        emit    = !p_rise && cnt_done;
        seq_set = seq_set | p_rise | r_fall | l1_rise;
      end
      StLineEnd: begin
        line_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Settle counter, pixel index and reset-level sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      idx        <= '0;
      rst_valid  <= 1'b0;
      rst_smp    <= '0;
    end else begin
      if (cnt_load) begin
        settle_cnt <= SW'(SETTLE);
      end else if (settle_cnt != '0) begin
        settle_cnt <= settle_cnt - SW'(1);
      end

      if (line_start) begin
        idx <= '0;
      end else if (emit) begin
        idx <= idx + CNT_W'(1);
      end

      if (line_start || emit) begin
        rst_valid <= 1'b0;
      end else if (smp_rst) begin
        rst_valid <= 1'b1;
      end

      if (smp_rst) begin
        rst_smp <= adc_data;
      end
    end
  end

  // Output register; a pixel arriving while the held one is unaccepted is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data  <= '0;
      pix_idx   <= '0;
      pix_sol   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_valid <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      if (emit && (!pix_valid || pix_ready)) begin
        pix_data  <= cds_pix;
        pix_idx   <= idx;
        pix_sol   <= (idx == '0);
        pix_eol   <= idx_last;
        pix_valid <= 1'b1;
      end else begin
        if (emit) begin
          ovf_err <= 1'b1;
        end
        if (pix_valid && pix_ready) begin
          pix_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
    end else if (seq_set) begin
      seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccd_line_capture.sv
// Bench for ccd_line_capture: drives phase-clock lines with random video levels and checks
// pixels, markers, latency and error flags against a level-based CDS reference model.
module tb_ccd_line_capture;

  localparam int unsigned ADC_W  = 12;
  localparam int unsigned NPIX   = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int          HOLD   = 8;
`ifdef CCD_RX_SYNC_EN
  localparam int          LAT    = SETTLE + 4;
`else
  localparam int          LAT    = SETTLE + 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             phi_p, phi_l1, phi_l2, phi_r;
  logic [ADC_W-1:0] adc_data;
  logic [ADC_W-1:0] pix_data;
  logic [CNT_W-1:0] pix_idx;
  logic             pix_sol, pix_eol, pix_valid, pix_ready;
  logic             line_done, ovf_err, seq_err;

  ccd_line_capture #(
    .ADC_W (ADC_W),
    .NPIX  (NPIX),
    .SETTLE(SETTLE),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .phi_p    (phi_p),
    .phi_l1   (phi_l1),
    .phi_l2   (phi_l2),
    .phi_r    (phi_r),
    .adc_data (adc_data),
    .pix_data (pix_data),
    .pix_idx  (pix_idx),
    .pix_sol  (pix_sol),
    .pix_eol  (pix_eol),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .line_done(line_done),
    .ovf_err  (ovf_err),
    .seq_err  (seq_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [ADC_W-1:0] data;
    logic [CNT_W-1:0] idx;
    logic             sol;
    logic             eol;
    int               cyc;
  } pix_t;

  pix_t got[$];
  int   l1_q[$];
  int   done_cnt = 0;
  pix_t mon_p;

  // Log every accepted pixel and every line_done pulse
  always @(negedge clk) begin
    if (rst_n && pix_valid && pix_ready) begin
      mon_p.data = pix_data;
      mon_p.idx  = pix_idx;
      mon_p.sol  = pix_sol;
      mon_p.eol  = pix_eol;
      mon_p.cyc  = cyc;
      got.push_back(mon_p);
    end
    if (rst_n && line_done) done_cnt++;
  end

  int checks = 0;
  int passed = 0;

  logic [ADC_W-1:0] rst_lv[NPIX+1];
  logic [ADC_W-1:0] sig_lv[NPIX+1];

  // Reference: pixel for period i is reset level of period i-1 minus signal of period i
  function automatic logic [ADC_W-1:0] ref_pix(input int i);
    int d;
    d = int'(rst_lv[i-1]) - int'(sig_lv[i]);
    return (d < 0) ? '0 : ADC_W'(d);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got.delete();
    l1_q.delete();
    done_cnt = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    {phi_p, phi_l1, phi_l2, phi_r} = '0;
    adc_data  = '0;
    pix_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    clear_logs();
  endtask

  task automatic set_levels(input bit rnd, input logic [ADC_W-1:0] r, input logic [ADC_W-1:0] s);
    for (int i = 0; i <= int'(NPIX); i++) begin
      rst_lv[i] = rnd ? ADC_W'($urandom_range(4095, 0)) : r;
      sig_lv[i] = rnd ? ADC_W'($urandom_range(4095, 0)) : s;
    end
  endtask

  task automatic p_pulse();
    phi_p = 1'b1;
    tick(HOLD);
    phi_p = 1'b0;
    tick(HOLD);
  endtask

  // One horizontal period: l1 / r+l2 / l2
  task automatic drive_period(input int i);
    phi_l1 = 1'b1; phi_l2 = 1'b0; phi_r = 1'b0; adc_data = sig_lv[i];
    if (i > 0) l1_q.push_back(cyc);
    tick(HOLD);
    phi_l1 = 1'b0; phi_l2 = 1'b1; phi_r = 1'b1; adc_data = rst_lv[i];
    tick(HOLD);
    phi_r = 1'b0;
    tick(HOLD);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {phi_p, phi_l1, phi_l2, phi_r} = '0;
    adc_data  = 12'hABC;
    pix_ready = 1'b1;
    tick(2);
    checks++;
    if ({pix_data, pix_idx, pix_sol, pix_eol, pix_valid, line_done, ovf_err, seq_err} !== '0)
      $display("FAIL reset_outputs: got data=%0h idx=%0d v=%b ld=%b ovf=%b seq=%b, want all 0",
               pix_data, pix_idx, pix_valid, line_done, ovf_err, seq_err);
    else passed++;
    rst_n = 1'b1;
    tick(4);
    checks++;
    if (pix_valid !== 1'b0 || seq_err !== 1'b0)
      $display("FAIL reset_idle: got valid=%b seq=%b, want 0 0", pix_valid, seq_err);
    else passed++;
    clear_logs();
  endtask

  task automatic test_line(input string name, input bit rnd, input int nlines,
                           input logic [ADC_W-1:0] r, input logic [ADC_W-1:0] s);
    int n;
    apply_reset();
    set_levels(rnd, r, s);
    for (int l = 0; l < nlines; l++) begin
      p_pulse();
      for (int i = 0; i <= int'(NPIX); i++) drive_period(i);
    end
    tick(4);
    n = nlines * int'(NPIX);
    checks++;
    if (got.size() !== n)
      $display("FAIL %s count: got %0d pixels, want %0d", name, got.size(), n);
    else passed++;
    for (int k = 0; k < got.size() && k < n; k++) begin
      int p;
      p = k % int'(NPIX);
      checks++;
      if (got[k].data !== ref_pix(p + 1))
        $display("FAIL %s data[%0d]: got %0h want %0h", name, k, got[k].data, ref_pix(p + 1));
      else passed++;
      checks++;
      if (got[k].idx !== CNT_W'(p) || got[k].sol !== (p == 0) ||
          got[k].eol !== (p == int'(NPIX) - 1))
        $display("FAIL %s marks[%0d]: got idx=%0d sol=%b eol=%b want idx=%0d", name, k,
                 got[k].idx, got[k].sol, got[k].eol, p);
      else passed++;
      checks++;
      if (got[k].cyc - l1_q[k] !== LAT)
        $display("FAIL %s latency[%0d]: got %0d want %0d", name, k, got[k].cyc - l1_q[k], LAT);
      else passed++;
    end
    checks++;
    if (done_cnt !== nlines)
      $display("FAIL %s line_done: got %0d pulses want %0d", name, done_cnt, nlines);
    else passed++;
    checks++;
    if (ovf_err !== 1'b0 || seq_err !== 1'b0 || pix_valid !== 1'b0)
      $display("FAIL %s flags: got ovf=%b seq=%b valid=%b want 0 0 0", name, ovf_err, seq_err,
               pix_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_levels(1'b0, 12'hA00, 12'h123);
    pix_ready = 1'b0;
    p_pulse();
    drive_period(0);
    drive_period(1);
    checks++;
    if (pix_valid !== 1'b1 || pix_idx !== '0 || pix_data !== ref_pix(1) || ovf_err !== 1'b0)
      $display("FAIL bp_first: got v=%b idx=%0d data=%0h ovf=%b want 1 0 %0h 0", pix_valid,
               pix_idx, pix_data, ovf_err, ref_pix(1));
    else passed++;
    drive_period(2);
    checks++;
    if (ovf_err !== 1'b1 || pix_idx !== '0 || pix_data !== ref_pix(1))
      $display("FAIL bp_second: got ovf=%b idx=%0d data=%0h want 1 0 %0h", ovf_err, pix_idx,
               pix_data, ref_pix(1));
    else passed++;
    drive_period(3);
    drive_period(4);
    tick(4);
    checks++;
    if (pix_valid !== 1'b1 || pix_idx !== '0 || done_cnt !== 1)
      $display("FAIL bp_hold: got v=%b idx=%0d done=%0d want 1 0 1", pix_valid, pix_idx,
               done_cnt);
    else passed++;
    pix_ready = 1'b1;
    tick(6);
    checks++;
    if (got.size() !== 1)
      $display("FAIL bp_drain_count: got %0d pixels want 1", got.size());
    else passed++;
    if (got.size() > 0) begin
      checks++;
      if (got[0].idx !== '0 || got[0].data !== ref_pix(1))
        $display("FAIL bp_drain_pix: got idx=%0d data=%0h want 0 %0h", got[0].idx, got[0].data,
                 ref_pix(1));
      else passed++;
    end
    checks++;
    if (pix_valid !== 1'b0 || ovf_err !== 1'b1)
      $display("FAIL bp_after: got v=%b ovf=%b want 0 1", pix_valid, ovf_err);
    else passed++;
  endtask

  task automatic test_short_line();
    apply_reset();
    set_levels(1'b1, '0, '0);
    p_pulse();
    for (int i = 0; i <= 2; i++) drive_period(i);
    checks++;
    if (seq_err !== 1'b0 || got.size() !== 2)
      $display("FAIL short_pre: got seq=%b pixels=%0d want 0 2", seq_err, got.size());
    else passed++;
    phi_p = 1'b1;
    tick(HOLD);
    checks++;
    if (seq_err !== 1'b1)
      $display("FAIL short_seq_err: got %b want 1", seq_err);
    else passed++;
    phi_p = 1'b0;
    tick(HOLD);
    checks++;
    if (done_cnt !== 0)
      $display("FAIL short_no_done: got %0d pulses want 0", done_cnt);
    else passed++;
    clear_logs();
    p_pulse();
    for (int i = 0; i <= int'(NPIX); i++) drive_period(i);
    tick(4);
    checks++;
    if (got.size() !== int'(NPIX) || done_cnt !== 1)
      $display("FAIL short_next_line: got %0d pixels %0d done want %0d 1", got.size(), done_cnt,
               NPIX);
    else passed++;
    for (int k = 0; k < got.size() && k < int'(NPIX); k++) begin
      checks++;
      if (got[k].idx !== CNT_W'(k) || got[k].data !== ref_pix(k + 1))
        $display("FAIL short_next_pix[%0d]: got idx=%0d data=%0h want %0d %0h", k, got[k].idx,
                 got[k].data, k, ref_pix(k + 1));
      else passed++;
    end
    checks++;
    if (seq_err !== 1'b1)
      $display("FAIL short_sticky: got %b want 1", seq_err);
    else passed++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_levels(1'b0, 12'h800, 12'h300);
    pix_ready = 1'b0;
    p_pulse();
    drive_period(0);
    drive_period(1);
    phi_l1 = 1'b1; phi_l2 = 1'b0; phi_r = 1'b0; adc_data = sig_lv[2];
    tick(LAT - 1);
    checks++;
    if (pix_valid !== 1'b1 || pix_sol !== 1'b1 || pix_data !== 12'h500)
      $display("FAIL arst_pre: got v=%b sol=%b data=%0h want 1 1 500", pix_valid, pix_sol,
               pix_data);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pix_data, pix_idx, pix_sol, pix_eol, pix_valid, line_done, ovf_err, seq_err} !== '0)
      $display("FAIL arst_outputs: got data=%0h idx=%0d v=%b sol=%b ld=%b want all 0", pix_data,
               pix_idx, pix_valid, pix_sol, line_done);
    else passed++;
    {phi_p, phi_l1, phi_l2, phi_r} = '0;
    tick(2);
    rst_n = 1'b1;
    pix_ready = 1'b1;
    tick(2);
    clear_logs();
    for (int i = 1; i <= int'(NPIX); i++) drive_period(i);
    tick(4);
    checks++;
    if (got.size() !== 0 || done_cnt !== 0)
      $display("FAIL arst_wait_phi_p: got %0d pixels %0d done want 0 0", got.size(), done_cnt);
    else passed++;
    clear_logs();
    p_pulse();
    for (int i = 0; i <= int'(NPIX); i++) drive_period(i);
    tick(4);
    checks++;
    if (got.size() !== int'(NPIX) || done_cnt !== 1)
      $display("FAIL arst_next_line: got %0d pixels %0d done want %0d 1", got.size(), done_cnt,
               NPIX);
    else passed++;
    if (got.size() > 0) begin
      checks++;
      if (got[0].idx !== '0 || got[0].data !== 12'h500)
        $display("FAIL arst_first_pix: got idx=%0d data=%0h want 0 500", got[0].idx,
                 got[0].data);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_line("nominal", 1'b0, 1, 12'h800, 12'h300);
    test_line("clamp", 1'b0, 1, 12'h100, 12'h200);
    test_line("random", 1'b1, 1, '0, '0);
    test_line("back_to_back", 1'b1, 2, '0, '0);
    test_backpressure();
    test_short_line();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/ccd_line_capture.md
Name: ccd_line_capture

Overview:
- Receive-side counterpart of the CCD clock sequencer `digital_cs`.
- Monitors the four CCD phase clocks (phi_p, phi_l1, phi_l2, phi_r) and samples the video ADC word at fixed offsets after phase edges.
- Produces correlated-double-sampled (CDS) pixels as a valid/ready stream, with line start/end markers and error flags.
- Sits between the CCD analog front-end ADC and the frame buffer / SoC bus.

Parameters:
- ADC_W, 12, ADC sample width and pixel width.
- NPIX, 2051, pixels per line; one fewer than the 2052 phase periods because the first period has no preceding reset sample.
- SETTLE, 8, clk cycles from a qualifying phase edge to the ADC sample strobe; must be ≥1.
- CNT_W, 12, pixel index width; 2^CNT_W must be ≥ NPIX.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- phi_p  in  1  transfer-gate clock from sequencer
- phi_l1  in  1  horizontal phase 1
- phi_l2  in  1  horizontal phase 2
- phi_r  in  1  reset-gate clock
- adc_data  in  ADC_W  CCD video ADC output, stable while sampled
- pix_data  out  ADC_W  CDS pixel value
- pix_idx  out  CNT_W  pixel index within line, 0..NPIX-1
- pix_sol  out  1  marks pixel index 0
- pix_eol  out  1  marks pixel index NPIX-1
- pix_valid  out  1  pixel available
- pix_ready  in  1  downstream accept
- line_done  out  1  one-cycle pulse when line completes
- ovf_err  out  1  sticky: pixel dropped due to backpressure
- seq_err  out  1  sticky: illegal phase sequence or short line

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; counters and sample registers cleared.
- Edge detection: registered copies of the phase inputs, one cycle each. Detects phi_p fall, phi_r fall and phi_l1 rise.
- FSM states: IDLE, ARMED, RST_WAIT, SIG_WAIT, LINE_END.
  - IDLE → ARMED on phi_p fall; pixel index := 0, rst_valid := 0.
  - ARMED, on phi_r fall: load settle counter := SETTLE → RST_WAIT.
  - ARMED, on phi_l1 rise: if rst_valid, load settle counter → SIG_WAIT; else remain in ARMED, because the first signal period is a dummy.
  - RST_WAIT: at counter 0, rst_smp := adc_data, rst_valid := 1 → ARMED.
  - SIG_WAIT: at counter 0, sig := adc_data; emit pixel; rst_valid := 0. Index == NPIX-1 → LINE_END, else → ARMED.
  - LINE_END: line_done pulses for 1 cycle → IDLE.
- Sample timing: the sample occurs exactly SETTLE cycles after the registered edge is detected.
- Phase edges arriving during RST_WAIT or SIG_WAIT: phi_r fall or phi_l1 rise sets seq_err; the wait continues uninterrupted.
- CDS arithmetic: pix = rst_smp − sig, unsigned, computed in ADC_W+1 bits. A negative result clamps to 0.
- Output register:
  - A new pixel loads pix_data/idx/sol/eol and sets pix_valid.
  - Transfer occurs on pix_valid && pix_ready, which clears pix_valid.
  - A new pixel arriving while pix_valid && !pix_ready: the new pixel is dropped, the register is held, ovf_err := 1, and the index still increments.
  - Transfer and a new pixel in the same cycle: the new pixel is loaded and no error is flagged.
- phi_p rise in any state other than IDLE/LINE_END: seq_err := 1. Partial line abandoned → IDLE; no line_done pulse.
- phi_p high while phi_l1 high: seq_err := 1.
- Sticky flags clear only on reset.
- rst_n asserted mid-line: immediate return to reset values; any pending pixel is lost.

Optional Feature:
- CCD_RX_SYNC_EN defined:
  - Each phi input passes through a 2-flop synchronizer before edge detection.
  - All edge-to-sample latencies grow by 2 cycles.
  - Required when the sequencer runs on an unrelated clock.
- Undefined: phase inputs feed the edge-detect registers directly, for a same-domain sequencer.

Test Plan:
- Nominal line (ADC_W=12, NPIX=4, SETTLE=2), pix_ready=1. Stimulus: phi_p pulse, then 5 periods (l1 / r+l2 / l2), with adc_data=0x800 during reset sampling and 0x300 during signal sampling. Required: 4 pixels of 0x500, idx 0..3, sol on idx 0, eol on idx 3, one line_done pulse, no error flags.
- Clamp: reset-level 0x100, signal 0x200. Required: pix_data=0x000.
- Backpressure: pix_ready=0 throughout. Required: first pixel held with pix_valid=1; ovf_err=1 after the second pixel; pix_idx stays 0. Raising pix_ready afterwards delivers only idx 0.
- Short line: phi_p rises after 2 of 4 pixels. Required: seq_err=1, no line_done; the next line runs normally from idx 0.
- Async reset: rst_n low during SIG_WAIT. Required: all outputs 0 in the same cycle; after release, the block waits for the next phi_p fall.
- With CCD_RX_SYNC_EN: rerun the nominal line. Required: identical pixel values, with each sample strobe 2 cycles later than without the macro.
